// File: rtl/rgb_pwm_pkg.sv
// Shared types and constants for the RGB PWM driver.
package rgb_pwm_pkg;

    localparam int PWM_STEPS = 255;

    typedef logic [7:0] duty_t;

    typedef struct packed {
        duty_t r;
        duty_t g;
        duty_t b;
    } rgb_t;

endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM colour channel: duty register, optional fade step (RGB_PWM_FADE_EN), compare flop.
module pwm_channel
    import rgb_pwm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  enable,
    input  logic  load,
    input  duty_t cnt,
    input  duty_t target,
    output logic  pwm
);

    duty_t duty;
    duty_t duty_next;
    duty_t duty_sel;

`ifdef RGB_PWM_FADE_EN
    // Walk one step per period toward the requested colour.
    always_comb begin
        duty_next = duty;
        if (duty < target)
            duty_next = duty + 8'd1;
        else if (duty > target)
            duty_next = duty - 8'd1;
    end
`else
    assign duty_next = target;
`endif

    // Compare against the freshly loaded value so the first tick of a period is correct.
    assign duty_sel = load ? duty_next : duty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty <= '0;
            pwm  <= 1'b0;
        end else if (!enable) begin
            duty <= '0;
            pwm  <= 1'b0;
        end else begin
            if (load)
                duty <= duty_next;
            pwm <= (cnt < duty_sel);
        end
    end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM LED driver; owns prescaler, period counter and boundary detection.
// Optional per-period colour fading is enabled with RGB_PWM_FADE_EN.
module rgb_pwm_driver
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] light,
    output logic        pwm_r,
    output logic        pwm_g,
    output logic        pwm_b,
    output logic        period_start
);

    logic [15:0] prescaler;
    duty_t       cnt;
    logic        tick;
    logic        load;
    rgb_t        target;

    assign tick   = (prescaler == 16'(PRESCALE - 1));
    assign load   = enable && (cnt == 8'd0) && (prescaler == 16'd0);
    assign target = rgb_t'(light);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler    <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
        end else if (!enable) begin
            prescaler    <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            prescaler    <= tick ? 16'd0 : prescaler + 16'd1;
            // cnt runs 0..254 so a duty of 255 keeps the output high all period.
            if (tick)
                cnt <= (cnt == 8'(PWM_STEPS - 1)) ? 8'd0 : cnt + 8'd1;
            period_start <= load;
        end
    end

    pwm_channel u_ch_r (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .load   (load),
        .cnt    (cnt),
        .target (target.r),
        .pwm    (pwm_r)
    );

    pwm_channel u_ch_g (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .load   (load),
        .cnt    (cnt),
        .target (target.g),
        .pwm    (pwm_g)
    );

    pwm_channel u_ch_b (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .load   (load),
        .cnt    (cnt),
        .target (target.b),
        .pwm    (pwm_b)
    );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Self-checking bench: two driver instances (PRESCALE 1 and 3) against a time-based reference model.
module tb_rgb_pwm_driver;

    localparam int PS0 = 1;
    localparam int PS1 = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [23:0] light = '0;

    logic r0, g0, b0, s0;
    logic r1, g1, b1, s1;

    always #5 clk = ~clk;

    rgb_pwm_driver #(.PRESCALE(PS0)) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .light(light),
        .pwm_r(r0), .pwm_g(g0), .pwm_b(b0), .period_start(s0)
    );

    rgb_pwm_driver #(.PRESCALE(PS1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .light(light),
        .pwm_r(r1), .pwm_g(g1), .pwm_b(b1), .period_start(s1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Model: clocks elapsed since the run began; each period is 255*P clocks.
    int          t_m[2];
    int          duty_m[2][3];
    logic [3:0]  exp_m[2];

    function automatic int psc(input int i);
        return (i == 0) ? PS0 : PS1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            t_m[i] = 0;
            exp_m[i] = 4'h0;
            for (int c = 0; c < 3; c++) duty_m[i][c] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!enable) begin
                t_m[i] = 0;
                exp_m[i] = 4'h0;
                for (int c = 0; c < 3; c++) duty_m[i][c] = 0;
            end else begin
                int per, pos, p;
                p   = psc(i);
                per = 255 * p;
                pos = t_m[i] % per;
                if (pos == 0) begin
                    for (int c = 0; c < 3; c++) begin
                        int tgt;
                        tgt = (light >> (8 * (2 - c))) & 8'hFF;
`ifdef RGB_PWM_FADE_EN
                        if (duty_m[i][c] < tgt) duty_m[i][c]++;
                        else if (duty_m[i][c] > tgt) duty_m[i][c]--;
`else
                        duty_m[i][c] = tgt;
`endif
                    end
                end
                exp_m[i] = {pos < duty_m[i][0] * p, pos < duty_m[i][1] * p,
                            pos < duty_m[i][2] * p, pos == 0};
                t_m[i]++;
            end
        end
    endtask

    // One clock: inputs already set at the falling edge, check at the next falling edge.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk({tag, "_p1"}, {r0, g0, b0, s0}, exp_m[0]);
        chk({tag, "_p3"}, {r1, g1, b1, s1}, exp_m[1]);
    endtask

    task automatic run(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag);
    endtask

    int hi_g, hi_b;

    initial begin
        model_reset();
        #1;
        chk("reset_p1", {r0, g0, b0, s0}, 4'h0);
        chk("reset_p3", {r1, g1, b1, s1}, 4'h0);
        @(negedge clk);
        @(negedge clk);
        enable = 1'b1;
        light  = 24'hFF8000;
        rst    = 1'b0;
        run("full_half", 2 * 765);

        light = 24'h404040;
        while (t_m[0] % 255 != 0) step("pre404040");
        run("c404040", 20);
        light = 24'h101010;
        run("midchange", 600);

        // Explicit pulse-width tally over one PRESCALE=3 period.
        light = 24'h000301;
        while (t_m[1] % 765 != 0) step("pre000301");
        hi_g = 0;
        hi_b = 0;
        for (int k = 0; k < 765; k++) begin
            step("c000301");
            hi_g += g1;
            hi_b += b1;
        end
        chk("width_g_p3", hi_g, 9);
        chk("width_b_p3", hi_b, 3);
        run("c000301", 800);

        while (t_m[0] % 255 != 100) step("pre_rst");
        rst = 1'b1;
        #1;
        chk("rst_async_p1", {r0, g0, b0, s0}, 4'h0);
        chk("rst_async_p3", {r1, g1, b1, s1}, 4'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        run("after_rst", 300);

        enable = 1'b0;
        run("disabled", 50);
        enable = 1'b1;
        run("reenable", 800);

        for (int seg = 0; seg < 24; seg++) begin
            int n;
            light  = 24'($urandom);
            if (seg % 8 == 3) light = 24'hFF00FF;
            enable = ($urandom_range(0, 9) != 0);
            n = $urandom_range(1, 300);
            run("random", n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
